// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter colour path.
// Contents: colour word width, default LED count, the black colour word used
// for unlit slots, and the frame reader FSM state encoding.
package vu_pkg;

    localparam int DATA_W = 24;
    localparam int N_LEDS = 16;

    localparam logic [DATA_W-1:0] COLOUR_BLACK = 24'h000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

endpackage

// File: rtl/rom_frame_reader_if.sv
// Colour word stream from the frame reader to the LED serializer.
//   data  : colour word (GRB 8/8/8)
//   valid : data holds a word
//   ready : serializer accepts the word on this edge
//   last  : word belongs to the final LED slot of the frame
// master = frame reader, slave = serializer.
interface rom_frame_reader_if #(
    parameter int DATA_W = vu_pkg::DATA_W
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/rom_frame_reader.sv
// Read-side master for the VU meter colour ROM.
// Per frame request it walks N_LEDS slots: lit slots (idx < level) read
// ROM[base+idx] (address wraps), unlit slots emit black. Words leave on a
// valid/ready stream with last marking the final slot; o_done pulses once
// per completed frame.
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_start, i_base,
//   i_level                frame request (sampled only in IDLE)
//   o_busy, o_done         frame in progress / one-cycle frame end pulse
//   o_rom_addr, o_rom_ren,
//   i_rom_data             registered-read ROM port (1-cycle latency)
//   stream                 colour word stream to the serializer
module rom_frame_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = vu_pkg::DATA_W,
    parameter int N_LEDS = vu_pkg::N_LEDS,
    parameter int CNT_W  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_W-1:0]       i_base,
    input  logic [CNT_W-1:0]        i_level,
    output logic                    o_busy,
    output logic [ADDR_W-1:0]       o_rom_addr,
    output logic                    o_rom_ren,
    input  logic [DATA_W-1:0]       i_rom_data,
    rom_frame_reader_if.master      stream,
    output logic                    o_done
);

    import vu_pkg::*;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    lvl, lvl_nxt;
    logic [ADDR_W-1:0]   base, base_nxt;
    logic [ADDR_W-1:0]   addr_r, addr_nxt;
    logic                ren_r, ren_nxt;
    logic [DATA_W-1:0]   data_r, data_nxt;
    logic                valid_r, valid_nxt;
    logic                last_r, last_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;

    logic [CNT_W-1:0]    lvl_in;
    logic [CNT_W-1:0]    idx_inc;
    logic                is_last;

    assign lvl_in  = (i_level > CNT_W'(N_LEDS)) ? CNT_W'(N_LEDS) : i_level;
    assign idx_inc = idx + CNT_W'(1);
    assign is_last = (idx == CNT_W'(N_LEDS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            lvl     <= '0;
            base    <= '0;
            addr_r  <= '0;
            ren_r   <= 1'b0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            lvl     <= lvl_nxt;
            base    <= base_nxt;
            addr_r  <= addr_nxt;
            ren_r   <= ren_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            last_r  <= last_nxt;
            busy_r  <= busy_nxt;
            done_r  <= done_nxt;
        end
    end

    // The ROM request for a slot is registered on the edge that enters FETCH,
    // so the FETCH cycle itself presents ren/addr to the ROM and CAPTURE sees
    // the read data. ren defaults low, making it a single-cycle pulse.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        lvl_nxt   = lvl;
        base_nxt  = base;
        addr_nxt  = addr_r;
        ren_nxt   = 1'b0;
        data_nxt  = data_r;
        valid_nxt = valid_r;
        last_nxt  = last_r;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    base_nxt  = i_base;
                    lvl_nxt   = lvl_in;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    ren_nxt   = (lvl_in != '0);
                    addr_nxt  = i_base;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (idx < lvl) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    data_nxt  = DATA_W'(COLOUR_BLACK);
                    valid_nxt = 1'b1;
                    last_nxt  = is_last;
                    state_nxt = S_SEND;
                end
            end
            S_CAPTURE: begin
                data_nxt  = i_rom_data;
                valid_nxt = 1'b1;
                last_nxt  = is_last;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (stream.ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    if (last_r) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_inc;
                        ren_nxt   = (idx_inc < lvl);
                        addr_nxt  = base + ADDR_W'(idx_inc);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy       = busy_r;
    assign o_rom_addr   = addr_r;
    assign o_rom_ren    = ren_r;
    assign o_done       = done_r;
    assign stream.data  = data_r;
    assign stream.valid = valid_r;
    assign stream.last  = last_r;

endmodule

// File: tb/tb_rom_frame_reader.sv
// Self-checking bench for rom_frame_reader with a registered-read ROM model.
module tb_rom_frame_reader;

    localparam int ADDR_W = 8;
    localparam int DW     = 24;
    localparam int NL     = 16;
    localparam int CW     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    base = '0;
    logic [4:0]    level = '0;
    logic          busy, ren, done;
    logic [7:0]    addr;
    logic [23:0]   rom_q = '0;

    rom_frame_reader_if #(.DATA_W(DW)) s_if ();

    rom_frame_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DW),
        .N_LEDS (NL),
        .CNT_W  (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_base     (base),
        .i_level    (level),
        .o_busy     (busy),
        .o_rom_addr (addr),
        .o_rom_ren  (ren),
        .i_rom_data (rom_q),
        .stream     (s_if),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // ROM: 256 words, registered read with one cycle latency
    logic [23:0] rom_mem [256];
    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] b;
            b = 8'(a);
            rom_mem[a] = {b, ~b, b ^ 8'hA5};
        end
    end
    always @(posedge clk) if (ren) rom_q <= rom_mem[addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: expected words and ROM addresses for the running frame
    logic [23:0] exp_words [$];
    logic [7:0]  exp_addrs [$];
    bit          mon_en = 0;
    bit          in_frame = 0;
    bit          done_due = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          hs_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int          first_valid_cyc = -1;
    int          start_cyc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ren) begin
                rd_cnt++;
                check("rom_read_expected", 32'(exp_addrs.size() != 0), 1);
                if (exp_addrs.size() != 0) check("rom_addr", addr, exp_addrs.pop_front());
            end
            check("done", done, done_due);
            check("busy", busy, in_frame && !done_due);
            if (done) done_cnt++;
            done_due = 0;
            if (prev_stall) begin
                check("stall_valid", s_if.valid, 1);
                check("stall_data", s_if.data, prev_data);
                check("stall_last", s_if.last, prev_last);
            end
            if (s_if.valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (s_if.ready) begin
                    hs_cnt++;
                    check("word_expected", 32'(exp_words.size() != 0), 1);
                    if (exp_words.size() != 0) begin
                        check("word", s_if.data, exp_words.pop_front());
                        check("last", s_if.last, exp_words.size() == 0);
                        if (exp_words.size() == 0) done_due = 1;
                    end
                end
            end
            prev_stall = s_if.valid && !s_if.ready;
            prev_data  = s_if.data;
            prev_last  = s_if.last;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ren"}, ren, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, s_if.data, 0);
        check({tag, "_valid"}, s_if.valid, 0);
        check({tag, "_last"}, s_if.last, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic build_model(input logic [7:0] b, input int lv, output int lvl);
        lvl = (lv > NL) ? NL : lv;
        exp_words.delete();
        exp_addrs.delete();
        for (int i = 0; i < NL; i++) begin
            logic [7:0] a;
            a = b + 8'(i);
            if (i < lvl) begin
                exp_addrs.push_back(a);
                exp_words.push_back(rom_mem[a]);
            end else begin
                exp_words.push_back(24'h000000);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int lv, input bit rand_rdy,
                             input int stall_word, input bit noisy, input int abort_after);
        int lvl;
        int budget;
        int stall_left;
        bit aborted;
        build_model(b, lv, lvl);
        hs_cnt = 0; rd_cnt = 0; done_cnt = 0; first_valid_cyc = -1;
        prev_stall = 0; done_due = 0;
        stall_left = 20; budget = 0; aborted = 0;
        mon_en = 1;
        @(posedge clk); #1;
        start = 1; base = b; level = 5'(lv); s_if.ready = 1'b1;
        @(posedge clk); #1;
        start = 0; start_cyc = cyc; in_frame = 1;
        // later changes to base/level must not affect the running frame
        base = 8'($urandom); level = 5'($urandom);
        while (done !== 1'b1 && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
            if (abort_after >= 0 && hs_cnt == abort_after) begin
                aborted = 1;
                break;
            end
            if (stall_word >= 0 && hs_cnt == stall_word && s_if.valid && stall_left > 0) begin
                s_if.ready = 1'b0;
                stall_left--;
            end else if (rand_rdy) begin
                s_if.ready = 1'($urandom_range(0, 1));
            end else begin
                s_if.ready = 1'b1;
            end
            start = noisy && (hs_cnt < NL - 1) && ($urandom_range(0, 3) == 0);
        end
        start = 0;
        if (aborted) begin
            rst_n = 0; mon_en = 0; in_frame = 0;
            @(posedge clk); #1;
            check_all_zero("abort");
            rst_n = 1; s_if.ready = 1'b1;
            exp_words.delete(); exp_addrs.delete();
            done_due = 0; prev_stall = 0; done_cnt = 0;
            mon_en = 1;
            repeat (6) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt, 0);
        end else begin
            check("frame_timeout", done, 1);
            in_frame = 0;
            repeat (2) @(posedge clk);
            #1;
            check("handshakes", hs_cnt, NL);
            check("rom_reads", rd_cnt, lvl);
            check("done_pulses", done_cnt, 1);
            check("words_left", exp_words.size(), 0);
            check("first_valid_latency", first_valid_cyc - start_cyc, (lvl > 0) ? 2 : 1);
        end
    endtask

    initial begin
        int lvl_tmp;
        s_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;

        // hand-computed ROM/model pins
        check("pin_rom00", rom_mem[8'h00], 24'h00FFA5);
        check("pin_rom10", rom_mem[8'h10], 24'h10EFB5);
        check("pin_romfc", rom_mem[8'hFC], 24'hFC0359);
        build_model(8'hFC, 8, lvl_tmp);
        check("pin_wrap_addr", exp_addrs[4], 8'h00);
        check("pin_wrap_word", exp_words[4], 24'h00FFA5);
        check("pin_black", exp_words[8], 24'h000000);
        build_model(8'h00, 31, lvl_tmp);
        check("pin_clamp", lvl_tmp, 16);

        run_frame(8'h00, 16, 0, -1, 0, -1);
        run_frame(8'h10, 5,  0, -1, 0, -1);
        run_frame(8'h20, 0,  0, -1, 0, -1);
        run_frame(8'h30, 31, 0, -1, 0, -1);
        run_frame(8'hFC, 8,  0, -1, 0, -1);
        run_frame(8'h40, 12, 1, 3,  1, -1);
        run_frame(8'h50, 16, 0, -1, 0, 8);
        run_frame(8'h60, 16, 0, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
